// File: rtl/datapath_seq.sv
// Sequenced RISC datapath: register file, A/B/C pipeline registers,
// shifter, ALU, {Z,N,V} flags and PC, driven by an internal
// IDLE->LOADA->LOADB->EXEC->WB sequencer with a start/done handshake.
// Ports: clk, resetn (async, active low), start; decoder fields
//   rn/rm/rd, shift, ALUop, vsel, asel, bsel, wb_en; data inputs
//   mdata, sximm5, sximm8; outputs busy, done, status, B, C, pc.
module datapath_seq #(
  parameter int WIDTH = 16,
  parameter int NREG  = 8,
  parameter int RW    = $clog2(NREG),
  parameter int PCW   = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [RW-1:0]    rn,
  input  logic [RW-1:0]    rm,
  input  logic [RW-1:0]    rd,
  input  logic [1:0]       shift,
  input  logic [1:0]       ALUop,
  input  logic [1:0]       vsel,
  input  logic             asel,
  input  logic             bsel,
  input  logic             wb_en,
  input  logic [WIDTH-1:0] mdata,
  input  logic [WIDTH-1:0] sximm5,
  input  logic [WIDTH-1:0] sximm8,
  output logic             busy,
  output logic             done,
  output logic [2:0]       status,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic [PCW-1:0]   pc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOADA,
    S_LOADB,
    S_EXEC,
    S_WB
  } state_t;

  state_t           r_state;
  logic [RW-1:0]    r_rn;
  logic [RW-1:0]    r_rm;
  logic [RW-1:0]    r_rd;
  logic [1:0]       r_shift;
  logic [1:0]       r_aluop;
  logic [1:0]       r_vsel;
  logic             r_asel;
  logic             r_bsel;
  logic             r_wben;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_c;
  logic [2:0]       r_status;
  logic [PCW-1:0]   r_pc;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_rf [NREG];

  logic [WIDTH-1:0] w_bsh;
  logic [WIDTH-1:0] w_ain;
  logic [WIDTH-1:0] w_bin;
  logic [WIDTH-1:0] w_res;
  logic             w_v;
  logic [WIDTH-1:0] w_wbval;

  always_comb begin
    w_bsh = r_b;
    case (r_shift)
      2'b01:   w_bsh = {r_b[WIDTH-2:0], 1'b0};
      2'b10:   w_bsh = {1'b0, r_b[WIDTH-1:1]};
      2'b11:   w_bsh = {r_b[WIDTH-1], r_b[WIDTH-1:1]};
      default: w_bsh = r_b;
    endcase
  end

  assign w_ain = r_asel ? '0 : r_a;
  assign w_bin = r_bsel ? sximm5 : w_bsh;

  // Overflow: add flips sign when operands agree,
  // subtract when they differ.
  always_comb begin
    w_res = '0;
    w_v   = 1'b0;
    case (r_aluop)
      2'b00: begin
        w_res = w_ain + w_bin;
        w_v   = ~(w_ain[WIDTH-1] ^ w_bin[WIDTH-1])
              & (w_ain[WIDTH-1] ^ w_res[WIDTH-1]);
      end
      2'b01: begin
        w_res = w_ain - w_bin;
        w_v   = (w_ain[WIDTH-1] ^ w_bin[WIDTH-1])
              & (w_ain[WIDTH-1] ^ w_res[WIDTH-1]);
      end
      2'b10:   w_res = w_ain & w_bin;
      default: w_res = ~w_bin;
    endcase
  end

  always_comb begin
    w_wbval = r_c;
    case (r_vsel)
      2'b01:   w_wbval = WIDTH'(r_pc);
      2'b10:   w_wbval = sximm8;
      2'b11:   w_wbval = mdata;
      default: w_wbval = r_c;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_rn     <= '0;
      r_rm     <= '0;
      r_rd     <= '0;
      r_shift  <= '0;
      r_aluop  <= '0;
      r_vsel   <= '0;
      r_asel   <= 1'b0;
      r_bsel   <= 1'b0;
      r_wben   <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_status <= '0;
      r_pc     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      for (int i = 0; i < NREG; i++)
        r_rf[i] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rn    <= rn;
            r_rm    <= rm;
            r_rd    <= rd;
            r_shift <= shift;
            r_aluop <= ALUop;
            r_vsel  <= vsel;
            r_asel  <= asel;
            r_bsel  <= bsel;
            r_wben  <= wb_en;
            r_busy  <= 1'b1;
            r_state <= S_LOADA;
          end
        end
        S_LOADA: begin
          r_a     <= r_rf[r_rn];
          r_state <= S_LOADB;
        end
        S_LOADB: begin
          r_b     <= r_rf[r_rm];
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_c      <= w_res;
          r_status <= {w_res == '0, w_res[WIDTH-1], w_v};
          r_done   <= 1'b1;
          r_state  <= S_WB;
        end
        S_WB: begin
          if (r_wben)
            r_rf[r_rd] <= w_wbval;
          r_pc    <= r_pc + PCW'(1);
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign status = r_status;
  assign B      = r_b;
  assign C      = r_c;
  assign pc     = r_pc;

endmodule

// File: tb/tb_datapath_seq.sv
// Directed bench for datapath_seq: default 16-bit instance plus
// a WIDTH=8/NREG=4/PCW=2 instance for wrap and ASR checks.
module tb_datapath_seq;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [2:0]  rn, rm, rd;
  logic [1:0]  shift, ALUop, vsel;
  logic        asel, bsel, wb_en;
  logic [15:0] mdata, sximm5, sximm8;
  logic        busy, done;
  logic [2:0]  status;
  logic [15:0] B, C;
  logic [7:0]  pc;

  logic        s_start;
  logic [1:0]  s_rn, s_rm, s_rd;
  logic [1:0]  s_shift, s_ALUop, s_vsel;
  logic        s_asel, s_bsel, s_wb_en;
  logic [7:0]  s_mdata, s_sximm5, s_sximm8;
  logic        s_busy, s_done;
  logic [2:0]  s_status;
  logic [7:0]  s_B, s_C;
  logic [1:0]  s_pc;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_pc   = 8'd0;

  always #5 clk = ~clk;

  datapath_seq u_dut (
    .clk(clk), .resetn(resetn), .start(start),
    .rn(rn), .rm(rm), .rd(rd),
    .shift(shift), .ALUop(ALUop), .vsel(vsel),
    .asel(asel), .bsel(bsel), .wb_en(wb_en),
    .mdata(mdata), .sximm5(sximm5), .sximm8(sximm8),
    .busy(busy), .done(done), .status(status),
    .B(B), .C(C), .pc(pc)
  );

  datapath_seq #(.WIDTH(8), .NREG(4), .PCW(2)) u_small (
    .clk(clk), .resetn(resetn), .start(s_start),
    .rn(s_rn), .rm(s_rm), .rd(s_rd),
    .shift(s_shift), .ALUop(s_ALUop), .vsel(s_vsel),
    .asel(s_asel), .bsel(s_bsel), .wb_en(s_wb_en),
    .mdata(s_mdata), .sximm5(s_sximm5), .sximm8(s_sximm8),
    .busy(s_busy), .done(s_done), .status(s_status),
    .B(s_B), .C(s_C), .pc(s_pc)
  );

  // One full transaction; decoder fields are scrambled after the
  // accepting edge to prove they were captured.
  task automatic do_op(
    input  logic [2:0]  a_rn, a_rm, a_rd,
    input  logic [1:0]  a_sh, a_op, a_vs,
    input  logic        a_as, a_bs, a_we,
    input  logic [15:0] a_i5, a_i8, a_md,
    output logic [15:0] ob, oc,
    output logic [2:0]  ost,
    output logic        odone, obusy
  );
    @(negedge clk);
    rn = a_rn; rm = a_rm; rd = a_rd;
    shift = a_sh; ALUop = a_op; vsel = a_vs;
    asel = a_as; bsel = a_bs; wb_en = a_we;
    sximm5 = a_i5; sximm8 = a_i8; mdata = a_md;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rn = ~a_rn; rm = ~a_rm; rd = ~a_rd;
    shift = ~a_sh; ALUop = ~a_op; vsel = ~a_vs;
    asel = ~a_as; bsel = ~a_bs; wb_en = ~a_we;
    obusy = busy;
    repeat (2) @(posedge clk);
    #1 ob = B;
    @(posedge clk);
    #1 oc = C; ost = status; odone = done;
    @(posedge clk); #1;
    exp_pc = exp_pc + 8'd1;
  endtask

  task automatic load_imm(input logic [2:0] r, input logic [15:0] v);
    logic [15:0] b_, c_; logic [2:0] s_; logic d_, y_;
    do_op(3'd0, 3'd0, r, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 1'b1,
          16'h0, v, 16'h0, b_, c_, s_, d_, y_);
  endtask

  task automatic read_reg(input logic [2:0] r, output logic [15:0] v);
    logic [15:0] c_; logic [2:0] s_; logic d_, y_;
    do_op(3'd0, r, 3'd0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0,
          16'h0, 16'h0, 16'h0, v, c_, s_, d_, y_);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    #1;
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_bd: got %b want 00", {busy, done});
    end
    n_checks++;
    if (status !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_status: got %b want 000", status);
    end
    n_checks++;
    if ({B, C, pc} !== 40'h0) begin
      n_fail++;
      $display("FAIL reset_bcpc: got %h %h %h want 0", B, C, pc);
    end
    exp_pc = 8'd0;
  endtask

  task automatic test_imm_load();
    logic [15:0] b_, c_, v; logic [2:0] s_; logic d_, y_;
    do_op(3'd0, 3'd0, 3'd3, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 1'b1,
          16'h0, 16'hFFF9, 16'h0, b_, c_, s_, d_, y_);
    n_checks++;
    if (d_ !== 1'b1 || y_ !== 1'b1) begin
      n_fail++;
      $display("FAIL imm_hs: got done=%b busy=%b want 1 1", d_, y_);
    end
    n_checks++;
    if (pc !== 8'd1 || done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL imm_pc: got pc=%h done=%b busy=%b want 01 0 0",
               pc, done, busy);
    end
    read_reg(3'd3, v);
    n_checks++;
    if (v !== 16'hFFF9) begin
      n_fail++;
      $display("FAIL imm_reg3: got %h want fff9", v);
    end
  endtask

  task automatic test_add_ovf();
    logic [15:0] b_, c_, v; logic [2:0] s_; logic d_, y_;
    load_imm(3'd1, 16'h7FFF);
    load_imm(3'd2, 16'h0001);
    do_op(3'd1, 3'd2, 3'd4, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1,
          16'h0, 16'h0, 16'h0, b_, c_, s_, d_, y_);
    n_checks++;
    if (c_ !== 16'h8000 || s_ !== 3'b011) begin
      n_fail++;
      $display("FAIL add_ovf: got C=%h st=%b want 8000 011", c_, s_);
    end
    read_reg(3'd4, v);
    n_checks++;
    if (v !== 16'h8000) begin
      n_fail++;
      $display("FAIL add_reg4: got %h want 8000", v);
    end
  endtask

  task automatic test_shift_sub();
    logic [15:0] b_, c_, v; logic [2:0] s_; logic d_, y_;
    load_imm(3'd5, 16'h0004);
    load_imm(3'd6, 16'h0008);
    do_op(3'd5, 3'd6, 3'd5, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0,
          16'h0, 16'h0, 16'h0, b_, c_, s_, d_, y_);
    n_checks++;
    if (b_ !== 16'h0008 || c_ !== 16'h0000 || s_ !== 3'b100) begin
      n_fail++;
      $display("FAIL sub_zero: got B=%h C=%h st=%b want 0008 0000 100",
               b_, c_, s_);
    end
    read_reg(3'd5, v);
    n_checks++;
    if (v !== 16'h0004) begin
      n_fail++;
      $display("FAIL sub_nowb: got %h want 0004", v);
    end
  endtask

  task automatic test_alu_misc();
    logic [15:0] b_, c_; logic [2:0] s_; logic d_, y_;
    do_op(3'd1, 3'd2, 3'd0, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0,
          16'h0, 16'h0, 16'h0, b_, c_, s_, d_, y_);
    n_checks++;
    if (c_ !== 16'h0001 || s_ !== 3'b000) begin
      n_fail++;
      $display("FAIL and: got C=%h st=%b want 0001 000", c_, s_);
    end
    do_op(3'd1, 3'd2, 3'd0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0,
          16'hFFF0, 16'h0, 16'h0, b_, c_, s_, d_, y_);
    n_checks++;
    if (c_ !== 16'hFFF0 || s_ !== 3'b010) begin
      n_fail++;
      $display("FAIL asel_bsel: got C=%h st=%b want fff0 010", c_, s_);
    end
    do_op(3'd1, 3'd2, 3'd0, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0,
          16'h0, 16'h0, 16'h0, b_, c_, s_, d_, y_);
    n_checks++;
    if (c_ !== 16'hFFFE || s_ !== 3'b010) begin
      n_fail++;
      $display("FAIL not: got C=%h st=%b want fffe 010", c_, s_);
    end
    do_op(3'd0, 3'd1, 3'd0, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0,
          16'h0, 16'h0, 16'h0, b_, c_, s_, d_, y_);
    n_checks++;
    if (c_ !== 16'hFFFE || s_ !== 3'b010) begin
      n_fail++;
      $display("FAIL lsl: got C=%h st=%b want fffe 010", c_, s_);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] b_, c_; logic [2:0] s_; logic d_, y_;
    do_op(3'd1, 3'd1, 3'd1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1,
          16'h0, 16'h0, 16'h0, b_, c_, s_, d_, y_);
    n_checks++;
    if (b_ !== 16'h7FFF || c_ !== 16'hFFFE || s_ !== 3'b011) begin
      n_fail++;
      $display("FAIL same_reg: got B=%h C=%h st=%b want 7fff fffe 011",
               b_, c_, s_);
    end
    do_op(3'd1, 3'd1, 3'd0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0,
          16'h0002, 16'h0, 16'h0, b_, c_, s_, d_, y_);
    n_checks++;
    if (b_ !== 16'hFFFE || c_ !== 16'h0000 || s_ !== 3'b100) begin
      n_fail++;
      $display("FAIL b2b: got B=%h C=%h st=%b want fffe 0000 100",
               b_, c_, s_);
    end
  endtask

  task automatic test_wb_sources();
    logic [15:0] b_, c_, v; logic [2:0] s_; logic d_, y_;
    logic [7:0] p;
    do_op(3'd0, 3'd0, 3'd7, 2'b00, 2'b00, 2'b11, 1'b0, 1'b0, 1'b1,
          16'h0, 16'h0, 16'hA5A5, b_, c_, s_, d_, y_);
    read_reg(3'd7, v);
    n_checks++;
    if (v !== 16'hA5A5) begin
      n_fail++;
      $display("FAIL wb_mdata: got %h want a5a5", v);
    end
    p = exp_pc;
    do_op(3'd0, 3'd0, 3'd6, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1,
          16'h0, 16'h0, 16'h0, b_, c_, s_, d_, y_);
    read_reg(3'd6, v);
    n_checks++;
    if (v !== {8'h00, p} || pc !== exp_pc) begin
      n_fail++;
      $display("FAIL wb_pc: got reg=%h pc=%h want %h %h",
               v, pc, {8'h00, p}, exp_pc);
    end
  endtask

  task automatic test_handshake();
    logic [23:0] dmask;
    logic [7:0]  pc0;
    int          nd;
    dmask = '0;
    nd = 0;
    @(negedge clk);
    pc0 = pc;
    rn = 3'd1; rm = 3'd2; rd = 3'd0; shift = 2'b00; ALUop = 2'b00;
    vsel = 2'b00; asel = 1'b0; bsel = 1'b0; wb_en = 1'b0;
    for (int i = 0; i < 24; i++) begin
      start = (i < 12);
      @(negedge clk);
      dmask[i] = done;
      if (done) nd++;
    end
    start = 1'b0;
    exp_pc = exp_pc + 8'd3;
    n_checks++;
    if (nd != 3 || dmask !== 24'h002108) begin
      n_fail++;
      $display("FAIL hs_count: got n=%0d mask=%h want 3 002108",
               nd, dmask);
    end
    n_checks++;
    if (pc !== pc0 + 8'd3) begin
      n_fail++;
      $display("FAIL hs_pc: got %h want %h", pc, pc0 + 8'd3);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] v;
    @(negedge clk);
    rn = 3'd0; rm = 3'd0; rd = 3'd3; shift = 2'b00; ALUop = 2'b00;
    vsel = 2'b10; asel = 1'b0; bsel = 1'b0; wb_en = 1'b1;
    sximm8 = 16'h1234;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    exp_pc = 8'd0;
    n_checks++;
    if ({busy, done, status} !== 5'b0) begin
      n_fail++;
      $display("FAIL rmid_ctl: got busy=%b done=%b st=%b want 0 0 000",
               busy, done, status);
    end
    n_checks++;
    if ({B, C, pc} !== 40'h0) begin
      n_fail++;
      $display("FAIL rmid_data: got %h %h %h want 0", B, C, pc);
    end
    @(negedge clk) resetn = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || pc !== 8'd0) begin
      n_fail++;
      $display("FAIL rmid_idle: got busy=%b pc=%h want 0 00", busy, pc);
    end
    read_reg(3'd3, v);
    n_checks++;
    if (v !== 16'h0000) begin
      n_fail++;
      $display("FAIL rmid_nowr: got %h want 0000", v);
    end
  endtask

  task automatic op8(
    input  logic [1:0] a_rm, a_rd, a_sh, a_vs,
    input  logic       a_as, a_we,
    input  logic [7:0] a_i8,
    output logic [7:0] ob, oc,
    output logic [2:0] ost
  );
    @(negedge clk);
    s_rn = 2'd0; s_rm = a_rm; s_rd = a_rd; s_shift = a_sh;
    s_ALUop = 2'b00; s_vsel = a_vs; s_asel = a_as; s_bsel = 1'b0;
    s_wb_en = a_we; s_sximm8 = a_i8;
    s_start = 1'b1;
    @(posedge clk); #1 s_start = 1'b0;
    repeat (2) @(posedge clk);
    #1 ob = s_B;
    @(posedge clk);
    #1 oc = s_C; ost = s_status;
    @(posedge clk); #1;
  endtask

  task automatic test_small();
    logic [7:0] b_, c_; logic [2:0] s_;
    op8(2'd0, 2'd1, 2'b00, 2'b10, 1'b0, 1'b1, 8'h80, b_, c_, s_);
    op8(2'd1, 2'd0, 2'b11, 2'b00, 1'b1, 1'b0, 8'h00, b_, c_, s_);
    n_checks++;
    if (b_ !== 8'h80 || c_ !== 8'hC0 || s_ !== 3'b010) begin
      n_fail++;
      $display("FAIL s_asr: got B=%h C=%h st=%b want 80 c0 010",
               b_, c_, s_);
    end
    op8(2'd0, 2'd2, 2'b00, 2'b01, 1'b0, 1'b1, 8'h00, b_, c_, s_);
    op8(2'd2, 2'd0, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00, b_, c_, s_);
    n_checks++;
    if (b_ !== 8'h02 || s_pc !== 2'd0) begin
      n_fail++;
      $display("FAIL s_pcwr: got reg2=%h pc=%h want 02 0", b_, s_pc);
    end
    op8(2'd0, 2'd3, 2'b00, 2'b01, 1'b0, 1'b1, 8'h00, b_, c_, s_);
    n_checks++;
    if (s_pc !== 2'd1) begin
      n_fail++;
      $display("FAIL s_wrap: got pc=%h want 1", s_pc);
    end
  endtask

  initial begin
    start = 1'b0; rn = '0; rm = '0; rd = '0;
    shift = '0; ALUop = '0; vsel = '0;
    asel = 1'b0; bsel = 1'b0; wb_en = 1'b0;
    mdata = '0; sximm5 = '0; sximm8 = '0;
    s_start = 1'b0; s_rn = '0; s_rm = '0; s_rd = '0;
    s_shift = '0; s_ALUop = '0; s_vsel = '0;
    s_asel = 1'b0; s_bsel = 1'b0; s_wb_en = 1'b0;
    s_mdata = '0; s_sximm5 = '0; s_sximm8 = '0;
    test_reset();
    test_imm_load();
    test_add_ovf();
    test_shift_sub();
    test_alu_misc();
    test_back_to_back();
    test_wb_sources();
    test_handshake();
    test_reset_mid();
    test_small();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
